// File: rtl/cordic_sched.sv
// Round-robin issue scheduler sharing one ena-stalled cordicProc pipeline between NREQ requesters.
// A {vld, tag} shadow pipe moves in lockstep with the datapath and labels each returning result.
module cordic_sched #(
    parameter int NREQ    = 4,
    parameter int TAGW    = 2,
    parameter int LATENCY = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_x,
    input  logic [16*NREQ-1:0]   req_y,
    output logic [NREQ-1:0]      req_ready,
    output logic                 cp_ena,
    output logic [15:0]          cp_xin,
    output logic [15:0]          cp_yin,
    input  logic [19:0]          cp_rout,
    input  logic [15:0]          cp_aout,
    output logic                 res_valid,
    output logic [TAGW-1:0]      res_tag,
    output logic [19:0]          res_r,
    output logic [15:0]          res_a,
    input  logic                 res_ready,
    output logic [4:0]           inflight
);
    logic [LATENCY-1:0] vld;
    logic [TAGW-1:0]    tag [LATENCY];
    logic [TAGW-1:0]    ptr;
    logic [TAGW-1:0]    gnt;
    logic               gnt_found;
    logic               adv;
    logic               issue;
    logic               res_hs;

    // The whole pipe advances unless a finished result is waiting on the consumer.
    assign adv       = !vld[LATENCY-1] || res_ready;
    assign cp_ena    = adv;
    assign issue     = adv && gnt_found;
    assign res_hs    = vld[LATENCY-1] && res_ready;

    assign res_valid = vld[LATENCY-1];
    assign res_tag   = tag[LATENCY-1];
    assign res_r     = cp_rout;
    assign res_a     = cp_aout;

    // Lowest requester at or above ptr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        gnt_found = 1'b0;
        gnt       = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found && req_valid[i] && (TAGW'(i) >= ptr)) begin
                gnt_found = 1'b1;
                gnt       = TAGW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found && req_valid[i]) begin
                gnt_found = 1'b1;
                gnt       = TAGW'(i);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        cp_xin    = '0;
        cp_yin    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (issue && (gnt == TAGW'(i))) begin
                req_ready[i] = 1'b1;
                cp_xin       = req_x[16*i +: 16];
                cp_yin       = req_y[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld      <= '0;
            ptr      <= '0;
            inflight <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                tag[s] <= '0;
            end
        end else begin
            if (adv) begin
                vld    <= {vld[LATENCY-2:0], issue};
                tag[0] <= issue ? gnt : '0;
                for (int s = 1; s < LATENCY; s++) begin
                    tag[s] <= tag[s-1];
                end
            end
            if (issue) begin
                ptr <= (gnt == TAGW'(NREQ-1)) ? '0 : gnt + TAGW'(1);
            end
            if (issue && !res_hs) begin
                inflight <= inflight + 5'd1;
            end else if (!issue && res_hs) begin
                inflight <= inflight - 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: a stand-in ena-gated cordicProc plus a queue-based scheduler model.
// Expected outputs come from issue order, per-entry advancing age and a rotating grant pointer.
module tb_cordic_sched;
    localparam int NREQ = 4;
    localparam int TAGW = 2;
    localparam int LAT  = 17;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [16*NREQ-1:0]  req_x;
    logic [16*NREQ-1:0]  req_y;
    logic [NREQ-1:0]     req_ready;
    logic                cp_ena;
    logic [15:0]         cp_xin;
    logic [15:0]         cp_yin;
    logic [19:0]         cp_rout;
    logic [15:0]         cp_aout;
    logic                res_valid;
    logic [TAGW-1:0]     res_tag;
    logic [19:0]         res_r;
    logic [15:0]         res_a;
    logic                res_ready;
    logic [4:0]          inflight;

    cordic_sched #(.NREQ(NREQ), .TAGW(TAGW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
        .cp_ena(cp_ena), .cp_xin(cp_xin), .cp_yin(cp_yin),
        .cp_rout(cp_rout), .cp_aout(cp_aout),
        .res_valid(res_valid), .res_tag(res_tag), .res_r(res_r), .res_a(res_a),
        .res_ready(res_ready), .inflight(inflight)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] f_r(input logic [15:0] x, input logic [15:0] y);
        return {x, 4'h0} ^ {4'h0, y};
    endfunction

    function automatic logic [15:0] lane(input logic [16*NREQ-1:0] v, input int idx);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i == idx) r = v[16*i +: 16];
        end
        return r;
    endfunction

    // Stand-in cordicProc: LAT ena-gated stages, no reset, deterministic transform.
    logic [19:0] pr [LAT];
    logic [15:0] pa [LAT];
    always_ff @(posedge clk) begin
        if (cp_ena) begin
            pr[0] <= f_r(cp_xin, cp_yin);
            pa[0] <= cp_yin;
            for (int s = 1; s < LAT; s++) begin
                pr[s] <= pr[s-1];
                pa[s] <= pa[s-1];
            end
        end
    end
    assign cp_rout = pr[LAT-1];
    assign cp_aout = pa[LAT-1];

    typedef struct {
        logic [TAGW-1:0] tag;
        logic [19:0]     r;
        logic [15:0]     a;
        int              t;
    } ent_t;

    ent_t            q[$];
    logic [TAGW-1:0] obs_tags[$];
    int              m_ptr   = 0;
    int              adv_cnt = 0;
    int              cyc     = 0;
    int              errors  = 0;
    int              checks  = 0;
    logic            e_tail, e_adv, e_found;
    int              e_g;
    logic [80:0]     exp_vec, obs_vec;

    // Compute this cycle's expectations from the model; inputs must stay put until step().
    task automatic eval();
        logic [NREQ-1:0] er;
        logic [NREQ-1:0] sh;
        logic [15:0]     ex, ey;
        logic [37:0]     eres;
        @(negedge clk);
        e_tail = 1'b0;
        if (q.size() > 0) e_tail = ((adv_cnt - q[0].t) == LAT);
        e_adv   = !e_tail || res_ready;
        e_found = 1'b0;
        e_g     = 0;
        if (e_adv) begin
            for (int k = 0; k < NREQ; k++) begin
                sh = req_valid >> ((m_ptr + k) % NREQ);
                if (!e_found && sh[0]) begin
                    e_found = 1'b1;
                    e_g     = (m_ptr + k) % NREQ;
                end
            end
        end
        er   = e_found ? (NREQ'(1) << e_g) : '0;
        ex   = e_found ? lane(req_x, e_g) : 16'h0;
        ey   = e_found ? lane(req_y, e_g) : 16'h0;
        eres = '0;
        if (e_tail) eres = {q[0].tag, q[0].r, q[0].a};
        exp_vec = {e_adv, er, ex, ey, e_tail, eres, 5'(q.size())};
        obs_vec = {cp_ena, req_ready, cp_xin, cp_yin, res_valid,
                   (res_valid ? {res_tag, res_r, res_a} : 38'h0), inflight};
        if (!rst && res_valid && res_ready) obs_tags.push_back(res_tag);
    endtask

    task automatic step();
        ent_t e;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ptr = 0;
        end else begin
            if (e_tail && res_ready) void'(q.pop_front());
            if (e_adv) begin
                if (e_found) begin
                    e.tag = TAGW'(e_g);
                    e.r   = f_r(lane(req_x, e_g), lane(req_y, e_g));
                    e.a   = lane(req_y, e_g);
                    e.t   = adv_cnt;
                    q.push_back(e);
                    m_ptr = (e_g + 1) % NREQ;
                end
                adv_cnt++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic rand_data();
        req_x = {$urandom(), $urandom()};
        req_y = {$urandom(), $urandom()};
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        req_x     = '0;
        req_y     = '0;
        repeat (2) begin
            eval();
            step();
        end
        rst = 1'b0;
        obs_tags.delete();
    endtask

    task automatic test_reset();
        do_reset();
        eval();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
        checks++; if (cp_ena !== 1'b1) begin errors++; $display("FAIL reset_cp_ena got=%b want=1", cp_ena); end
        checks++; if (inflight !== 5'd0) begin errors++; $display("FAIL reset_inflight got=%0d want=0", inflight); end
        step();
        req_valid = 4'b0100;
        eval();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL reset_first_grant got=%b want=0100", req_ready); end
        step();
        req_valid = '0;
    endtask

    task automatic test_single();
        int lat;
        int c0;
        logic [TAGW-1:0] gt;
        logic [19:0] gr;
        logic [15:0] ga;
        do_reset();
        req_valid = 4'b0001;
        req_x[15:0] = 16'sd1000;
        eval();
        checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL single_cycle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b want=0001", req_ready); end
        c0 = cyc;
        step();
        req_valid = '0;
        lat = -1; gt = '1; gr = '0; ga = '1;
        for (int i = 0; i < 22; i++) begin
            eval();
            checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL single_cycle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
            if (res_valid && lat < 0) begin
                lat = cyc - c0; gt = res_tag; gr = res_r; ga = res_a;
            end
            step();
        end
        checks++; if (lat != 17) begin errors++; $display("FAIL single_latency got=%0d want=17", lat); end
        checks++; if (gt !== 2'd0) begin errors++; $display("FAIL single_tag got=%0d want=0", gt); end
        checks++; if (ga !== 16'd0) begin errors++; $display("FAIL single_angle got=%0d want=0", ga); end
        checks++; if (gr !== f_r(16'd1000, 16'd0)) begin errors++; $display("FAIL single_mag got=%0d want=%0d", gr, f_r(16'd1000, 16'd0)); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            req_valid = 4'hf;
            rand_data();
            eval();
            checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL rr_cycle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
            checks++; if (req_ready !== (NREQ'(1) << (i % NREQ))) begin errors++; $display("FAIL rr_grant i=%0d got=%b want=%b", i, req_ready, NREQ'(1) << (i % NREQ)); end
            step();
        end
        req_valid = '0;
        for (int i = 0; i < 20; i++) begin
            eval();
            checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL rr_cycle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
            step();
        end
        checks++; if (obs_tags.size() != 12) begin errors++; $display("FAIL rr_result_count got=%0d want=12", obs_tags.size()); end
        for (int i = 0; i < obs_tags.size(); i++) begin
            checks++; if (obs_tags[i] !== TAGW'(i % NREQ)) begin errors++; $display("FAIL rr_result_tag i=%0d got=%0d want=%0d", i, obs_tags[i], i % NREQ); end
        end
    endtask

    task automatic test_skip_idle();
        logic [NREQ-1:0] want;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req_valid = 4'b1010;
            rand_data();
            eval();
            want = (i % 2 == 0) ? 4'b0010 : 4'b1000;
            checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL skip_cycle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
            checks++; if (req_ready !== want) begin errors++; $display("FAIL skip_grant i=%0d got=%b want=%b", i, req_ready, want); end
            step();
        end
        req_valid = '0;
        for (int i = 0; i < 20; i++) begin
            eval();
            checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL skip_cycle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
            step();
        end
        checks++; if (obs_tags.size() != 8) begin errors++; $display("FAIL skip_result_count got=%0d want=8", obs_tags.size()); end
    endtask

    task automatic test_back_pressure();
        int n_gnt, n_hs, first_issue;
        logic [37:0] held;
        do_reset();
        n_gnt = 0; n_hs = 0; first_issue = -1; held = '0;
        for (int i = 0; i < 17; i++) begin
            req_valid = 4'hf;
            rand_data();
            eval();
            checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL bp_cycle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
            if (i == 0) first_issue = cyc;
            if (|req_ready) n_gnt++;
            if (res_valid && res_ready) n_hs++;
            step();
        end
        res_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            rand_data();
            eval();
            checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL bp_cycle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
            checks++; if ({cp_ena, req_ready} !== 5'b0) begin errors++; $display("FAIL bp_stall j=%0d got=%b want=00000", j, {cp_ena, req_ready}); end
            if (j == 0) begin
                held = {res_tag, res_r, res_a};
                checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid got=%b want=1", res_valid); end
            end else begin
                checks++; if ({res_tag, res_r, res_a} !== held) begin errors++; $display("FAIL bp_hold j=%0d got=%h want=%h", j, {res_tag, res_r, res_a}, held); end
            end
            if (|req_ready) n_gnt++;
            step();
        end
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_data();
            eval();
            checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL bp_cycle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
            if (i == 0) begin
                checks++; if (!(res_valid && res_ready) || (cyc - first_issue) != 22) begin errors++; $display("FAIL bp_latency got=%0d valid=%b want=22", cyc - first_issue, res_valid); end
            end
            if (|req_ready) n_gnt++;
            if (res_valid && res_ready) n_hs++;
            step();
        end
        req_valid = '0;
        for (int i = 0; i < 30; i++) begin
            eval();
            checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL bp_cycle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
            if (res_valid && res_ready) n_hs++;
            step();
        end
        checks++; if (n_hs != n_gnt) begin errors++; $display("FAIL bp_conservation got=%0d results want=%0d", n_hs, n_gnt); end
        for (int i = 0; i < obs_tags.size(); i++) begin
            checks++; if (obs_tags[i] !== TAGW'(i % NREQ)) begin errors++; $display("FAIL bp_order i=%0d got=%0d want=%0d", i, obs_tags[i], i % NREQ); end
        end
    endtask

    task automatic test_bubbles();
        logic [4:0] max_inf;
        do_reset();
        max_inf = '0;
        for (int i = 0; i < 46; i++) begin
            req_valid = (i < 30 && i % 2 == 0) ? 4'b0001 : 4'b0000;
            rand_data();
            eval();
            checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL bubble_cycle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
            if (inflight > max_inf) max_inf = inflight;
            step();
        end
        checks++; if (max_inf !== 5'd9) begin errors++; $display("FAIL bubble_max_inflight got=%0d want=9", max_inf); end
    endtask

    task automatic test_reset_mid();
        int lat, c0;
        logic [TAGW-1:0] gt;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            req_valid = (i < 6) ? 4'hf : 4'h0;
            rand_data();
            eval();
            checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL midrst_cycle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
            step();
        end
        rst = 1'b1;
        eval();
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            eval();
            checks++; if ({res_valid, inflight} !== 6'd0) begin errors++; $display("FAIL midrst_quiet cyc=%0d got=%b/%0d want=0/0", cyc, res_valid, inflight); end
            step();
        end
        req_valid = 4'b0101;
        rand_data();
        eval();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_ptr got=%b want=0001", req_ready); end
        c0 = cyc;
        step();
        req_valid = '0;
        lat = -1; gt = '1;
        for (int k = 0; k < 25; k++) begin
            eval();
            checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL midrst_cycle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
            if (res_valid && lat < 0) begin lat = cyc - c0; gt = res_tag; end
            step();
        end
        checks++; if (lat != 17) begin errors++; $display("FAIL midrst_latency got=%0d want=17", lat); end
        checks++; if (gt !== 2'd0) begin errors++; $display("FAIL midrst_tag got=%0d want=0", gt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_valid = NREQ'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            eval();
            checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL rand_cycle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
            step();
        end
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            eval();
            checks++; if (obs_vec !== exp_vec) begin errors++; $display("FAIL rand_cycle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
            step();
        end
        checks++; if (inflight !== 5'd0) begin errors++; $display("FAIL rand_drain got=%0d want=0", inflight); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_skip_idle();
        test_back_pressure();
        test_bubbles();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end
endmodule
